// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer scan-out path: default
// 640x480 timing, pixel colour type, and framebuffer address widths.
package fb_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_SRC_W = 320;
    localparam int DEF_SRC_H = 240;
    localparam int DEF_X_OFF = 160;
    localparam int DEF_Y_OFF = 120;

    // Address widths the framebuffer memory is built around.
    localparam int FB_XW = 10;
    localparam int FB_YW = 9;

    typedef logic [23:0] rgb_t;

    localparam rgb_t DEF_FG     = 24'hFFFFFF;
    localparam rgb_t DEF_BG     = 24'h000000;
    localparam rgb_t DEF_BORDER = 24'h202020;

    // Per-pixel timing flags that travel alongside the framebuffer read.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic in_src;
        logic frame_start;
        logic line_start;
    } timing_t;

endpackage

// File: rtl/fb_scanout_if.sv
// Framebuffer read port between the scan-out engine (master) and the
// framebuffer memory (slave).
interface fb_scanout_if;

    // No handshake: the master presents fb_x/fb_y every cycle and the slave
    // returns fb_data a fixed FB_LAT cycles later, unconditionally.
    logic [fb_pkg::FB_XW-1:0] fb_x;
    logic [fb_pkg::FB_YW-1:0] fb_y;
    logic                     fb_data;

    modport master (
        output fb_x,
        output fb_y,
        input  fb_data
    );

    modport slave (
        input  fb_x,
        input  fb_y,
        output fb_data
    );

endinterface

// File: rtl/fb_delay.sv
// Fixed-depth shift register with asynchronous clear; aligns timing flags
// with data returning from the framebuffer.
module fb_delay #(
    parameter int W = 1,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sr [D];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= d;
            for (int i = 1; i < D; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[D-1];

endmodule

// File: rtl/fb_scanout.sv
// Video timing generator that scans a small 1-bit framebuffer into a
// centred window of the active area, with a border colour around it.
module fb_scanout
    import fb_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter bit   HS_POL   = 1'b0,
    parameter bit   VS_POL   = 1'b0,
    parameter int   SRC_W    = DEF_SRC_W,
    parameter int   SRC_H    = DEF_SRC_H,
    parameter int   X_OFF    = DEF_X_OFF,
    parameter int   Y_OFF    = DEF_Y_OFF,
    parameter int   FB_LAT   = 2,
    parameter rgb_t FG       = DEF_FG,
    parameter rgb_t BG       = DEF_BG,
    parameter rgb_t BORDER   = DEF_BORDER
) (
    input  logic         out_clk,
    input  logic         rst,
    fb_scanout_if.master fb,
    output logic         hsync,
    output logic         vsync,
    output logic         de,
    output rgb_t         rgb,
    output logic         frame_start,
    output logic         line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One spare count of headroom so a zero back porch cannot alias a bound to 0.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    if (X_OFF + SRC_W > H_ACTIVE) begin : g_chk_x_fit
        $error("fb_scanout: source window exceeds active width");
    end
    if (Y_OFF + SRC_H > V_ACTIVE) begin : g_chk_y_fit
        $error("fb_scanout: source window exceeds active height");
    end
    if (SRC_W > 1024) begin : g_chk_src_w
        $error("fb_scanout: SRC_W does not fit the fb_x address");
    end
    if (SRC_H > 512) begin : g_chk_src_h
        $error("fb_scanout: SRC_H does not fit the fb_y address");
    end
    if (FB_LAT < 1) begin : g_chk_lat
        $error("fb_scanout: FB_LAT must be at least 1");
    end

    logic [HW-1:0]    h_cnt;
    logic [VW-1:0]    v_cnt;
    timing_t          raw;
    timing_t          dly;
    logic [FB_XW-1:0] fb_x_q;
    logic [FB_YW-1:0] fb_y_q;

    always_ff @(posedge out_clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            if (v_cnt == VW'(V_TOTAL - 1)) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + 1'b1;
            end
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        raw             = '0;
        raw.hs          = (h_cnt >= HW'(HS_START)) && (h_cnt < HW'(HS_END));
        raw.vs          = (v_cnt >= VW'(VS_START)) && (v_cnt < VW'(VS_END));
        raw.de          = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
        raw.in_src      = raw.de
                          && (h_cnt >= HW'(X_OFF)) && (h_cnt < HW'(X_OFF + SRC_W))
                          && (v_cnt >= VW'(Y_OFF)) && (v_cnt < VW'(Y_OFF + SRC_H));
        raw.frame_start = (h_cnt == '0) && (v_cnt == '0);
        raw.line_start  = (h_cnt == '0) && (v_cnt < VW'(V_ACTIVE));
    end

    // Address register adds one cycle ahead of the memory latency.
    always_ff @(posedge out_clk or posedge rst) begin
        if (rst) begin
            fb_x_q <= '0;
            fb_y_q <= '0;
        end else if (raw.in_src) begin
            fb_x_q <= FB_XW'(h_cnt - HW'(X_OFF));
            fb_y_q <= FB_YW'(v_cnt - VW'(Y_OFF));
        end else begin
            fb_x_q <= '0;
            fb_y_q <= '0;
        end
    end

    assign fb.fb_x = fb_x_q;
    assign fb.fb_y = fb_y_q;

    fb_delay #(
        .W($bits(timing_t)),
        .D(FB_LAT + 1)
    ) u_delay (
        .clk(out_clk),
        .rst(rst),
        .d  (raw),
        .q  (dly)
    );

    assign hsync       = dly.hs ? HS_POL : ~HS_POL;
    assign vsync       = dly.vs ? VS_POL : ~VS_POL;
    assign de          = dly.de;
    assign frame_start = dly.frame_start;
    assign line_start  = dly.line_start;

    // fb_data is only meaningful while the aligned pixel lies in the source window.
    always_comb begin
        rgb = '0;
        if (dly.de) begin
            if (dly.in_src) begin
                rgb = fb.fb_data ? FG : BG;
            end else begin
                rgb = BORDER;
            end
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: a default 640x480 instance and a small inverted-sync,
// FB_LAT=3 instance, each fed by a checkerboard framebuffer model.
module tb_fb_scanout;

    localparam int EW  = 29;
    localparam int FBW = 19;

    typedef struct {
        int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, sw, sh, xo, yo, lat;
        bit hp, vp;
    } cfg_t;

    function automatic cfg_t get_cfg(input int id);
        cfg_t c;
        if (id == 0) c = '{640, 16, 96, 48, 480, 10, 2, 33, 320, 240, 160, 120, 2, 1'b0, 1'b0};
        else         c = '{40, 4, 6, 6, 20, 2, 2, 3, 16, 8, 10, 6, 3, 1'b1, 1'b1};
        return c;
    endfunction

    function automatic bit in_src(input cfg_t c, input int h, input int v);
        return h < c.ha && v < c.va && h >= c.xo && h < c.xo + c.sw && v >= c.yo && v < c.yo + c.sh;
    endfunction

    function automatic logic [EW-1:0] idle_out(input cfg_t c);
        return {~c.hp, ~c.vp, 1'b0, 24'h0, 1'b0, 1'b0};
    endfunction

    function automatic logic [EW-1:0] exp_out(input cfg_t c, input int h, input int v);
        bit hs, vs, act, fs, ls;
        logic [23:0] px;
        hs  = h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw;
        vs  = v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw;
        act = h < c.ha && v < c.va;
        if (!act) px = 24'h000000;
        else if (!in_src(c, h, v)) px = 24'h202020;
        else px = (((h - c.xo) ^ (v - c.yo)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
        fs = h == 0 && v == 0;
        ls = h == 0 && v < c.va;
        return {hs ? c.hp : ~c.hp, vs ? c.vp : ~c.vp, act, px, fs, ls};
    endfunction

    function automatic logic [FBW-1:0] exp_fb(input cfg_t c, input int h, input int v);
        if (in_src(c, h, v)) return {10'(h - c.xo), 9'(v - c.yo)};
        return '0;
    endfunction

    // ---------------- clock / reset ----------------
    logic out_clk = 1'b0;
    always #5 out_clk = ~out_clk;

    logic       rst_o   [2];
    logic       hsync_o [2];
    logic       vsync_o [2];
    logic       de_o    [2];
    logic [23:0] rgb_o  [2];
    logic       fs_o    [2];
    logic       ls_o    [2];
    logic [9:0] fbx_o   [2];
    logic [8:0] fby_o   [2];
    logic       fbd     [2];

    int tests;
    int fails;

    fb_scanout_if fb_a ();
    fb_scanout_if fb_b ();

    assign fbx_o[0] = fb_a.fb_x;
    assign fby_o[0] = fb_a.fb_y;
    assign fb_a.fb_data = fbd[0];
    assign fbx_o[1] = fb_b.fb_x;
    assign fby_o[1] = fb_b.fb_y;
    assign fb_b.fb_data = fbd[1];

    fb_scanout dut_a (
        .out_clk    (out_clk),
        .rst        (rst_o[0]),
        .fb         (fb_a),
        .hsync      (hsync_o[0]),
        .vsync      (vsync_o[0]),
        .de         (de_o[0]),
        .rgb        (rgb_o[0]),
        .frame_start(fs_o[0]),
        .line_start (ls_o[0])
    );

    fb_scanout #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b1), .VS_POL(1'b1),
        .SRC_W(16), .SRC_H(8), .X_OFF(10), .Y_OFF(6),
        .FB_LAT(3)
    ) dut_b (
        .out_clk    (out_clk),
        .rst        (rst_o[1]),
        .fb         (fb_b),
        .hsync      (hsync_o[1]),
        .vsync      (vsync_o[1]),
        .de         (de_o[1]),
        .rgb        (rgb_o[1]),
        .frame_start(fs_o[1]),
        .line_start (ls_o[1])
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- per-instance framebuffer model and scoreboard ----------------
    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 2 : 3;
        logic [EW-1:0]  exp_q[$];
        logic [FBW-1:0] fb_q[$];
        logic           pipe [LAT];
        int             mh;
        int             mv;
        bit             running = 1'b0;
        cfg_t           c;

        always @(posedge out_clk) begin
            pipe[0] <= fbx_o[g][0] ^ fby_o[g][0];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign fbd[g] = pipe[LAT-1];

        // Expected-response generator: one entry per counter state.
        always @(posedge out_clk) begin
            c = get_cfg(g);
            #2;
            if (rst_o[g]) begin
                running = 1'b0;
            end else begin
                if (!running) begin
                    exp_q.delete();
                    fb_q.delete();
                    for (int i = 0; i <= c.lat; i++) exp_q.push_back(idle_out(c));
                    fb_q.push_back('0);
                    mh = 0;
                    mv = 0;
                    running = 1'b1;
                end
                exp_q.push_back(exp_out(c, mh, mv));
                fb_q.push_back(exp_fb(c, mh, mv));
                mh++;
                if (mh == c.ha + c.hfp + c.hsw + c.hbp) begin
                    mh = 0;
                    mv++;
                    if (mv == c.va + c.vfp + c.vsw + c.vbp) mv = 0;
                end
            end
        end

        // Monitor: compares every output cycle against the queue head.
        always @(negedge out_clk) begin
            logic [EW-1:0] got;
            got = {hsync_o[g], vsync_o[g], de_o[g], rgb_o[g], fs_o[g], ls_o[g]};
            if (rst_o[g]) begin
                check($sformatf("lane%0d_reset_out", g), 64'(got), 64'(idle_out(get_cfg(g))));
                check($sformatf("lane%0d_reset_fb", g), 64'({fbx_o[g], fby_o[g]}), 64'd0);
            end else if (exp_q.size() == 0 || fb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL lane%0d_underflow: got empty queue expected an entry", g);
            end else begin
                check($sformatf("lane%0d_video", g), 64'(got), 64'(exp_q.pop_front()));
                check($sformatf("lane%0d_fb_addr", g), 64'({fbx_o[g], fby_o[g]}), 64'(fb_q.pop_front()));
            end
        end
    end

    // ---------------- directed timing observations ----------------
    int cyc0 = 0, rel0 = 0, cyc1 = 0;
    int de_first = -1, de_second = -1, hs_start = -1, hs_width = 0, fs_after = -1;
    int fs1_first = -1, fs1_second = -1;
    bit hs_done = 1'b0, de_prev = 1'b0, hs_prev = 1'b1;

    localparam int             TBL_CYC [5] = '{346, 347, 348, 754, 755};
    localparam logic [FBW-1:0] TBL_EXP [5] = '{19'h0, 19'h0, {10'd1, 9'd0}, {10'd15, 9'd7}, 19'h0};
    logic [FBW-1:0] fb_seen [5] = '{default: '1};

    always @(negedge out_clk) begin
        if (rst_o[0]) begin
            cyc0 = 0;
        end else begin
            if (cyc0 == 0) rel0++;
            if (rel0 == 1) begin
                if (de_o[0] && !de_prev) begin
                    if (de_first < 0) de_first = cyc0;
                    else if (de_second < 0) de_second = cyc0;
                end
                if (!hsync_o[0] && hs_prev && hs_start < 0) hs_start = cyc0;
                if (hs_start >= 0 && !hs_done) begin
                    if (!hsync_o[0]) hs_width++;
                    else hs_done = 1'b1;
                end
            end
            if (rel0 == 2 && fs_o[0] && fs_after < 0) fs_after = cyc0;
            cyc0++;
        end
        de_prev = de_o[0];
        hs_prev = hsync_o[0];

        if (rst_o[1]) begin
            cyc1 = 0;
        end else begin
            if (fs_o[1]) begin
                if (fs1_first < 0) fs1_first = cyc1;
                else if (fs1_second < 0) fs1_second = cyc1;
            end
            for (int i = 0; i < 5; i++) begin
                if (cyc1 == TBL_CYC[i]) fb_seen[i] = {fbx_o[1], fby_o[1]};
            end
            cyc1++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        tests = 0;
        fails = 0;
        rst_o[0] = 1'b1;
        rst_o[1] = 1'b1;
        repeat (4) @(posedge out_clk);
        #1;
        rst_o[0] = 1'b0;
        rst_o[1] = 1'b0;
        // Counter state (h=300, v=2) of the default instance is cycle 1900.
        repeat (1900) @(posedge out_clk);
        #1;
        rst_o[0] = 1'b1;
        repeat (5) @(posedge out_clk);
        #1;
        rst_o[0] = 1'b0;
        repeat (1300) @(posedge out_clk);
        @(negedge out_clk);
        #1;

        check("first_de_cycle", 64'(de_first), 64'd3);
        check("hsync_start_cycle", 64'(hs_start), 64'd659);
        check("hsync_width", 64'(hs_width), 64'd96);
        check("line_period", 64'(de_second - de_first), 64'd800);
        check("frame_start_after_reset", 64'(fs_after), 64'd3);
        check("small_first_frame_start", 64'(fs1_first), 64'd4);
        check("small_frame_period", 64'(fs1_second - fs1_first), 64'd1512);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("small_fb_addr_%0d", i), 64'(fb_seen[i]), 64'(TBL_EXP[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
